// File: rtl/pe_tap_sequencer.sv
// Tap sequencer for one PE: walks a KERNEL_SIZE-tap MAC window, drains the PE pipe, hands off psum.
// Optional stall counter enabled by defining PE_SEQ_STALL_CNT_EN.
module pe_tap_sequencer #(
  parameter int unsigned KERNEL_SIZE = 9,
  parameter int unsigned PIPE_LAT    = 2,
  parameter int unsigned CNT_W       = $clog2(KERNEL_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pe_en,
  output logic             mult_seln,
  output logic             acc_seln,
  output logic [CNT_W-1:0] tap_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic [31:0]      stall_cnt
);

  localparam int unsigned      LAT_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] TapLast = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [LAT_W-1:0] LatLast = LAT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tap_q, tap_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             done_q, done_d;
  logic             start_acc;
  logic             mult_sel_raw;

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    lat_d        = lat_q;
    done_d       = 1'b0;
    start_acc    = 1'b0;
    in_ready     = 1'b0;
    pe_en        = 1'b0;
    mult_sel_raw = 1'b1;
    acc_seln     = 1'b0;
    out_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StAccum;
          tap_d     = '0;
          start_acc = 1'b1;
        end
      end
      StAccum: begin
        in_ready     = 1'b1;
        pe_en        = in_valid;
        mult_sel_raw = ~in_valid;
        acc_seln     = in_valid && (tap_q == '0);
        if (in_valid) begin
          // Counter parks on the last tap so tap_idx never leaves 0..KERNEL_SIZE-1
          if (tap_q == TapLast) begin
            lat_d   = '0;
            state_d = (PIPE_LAT == 0) ? StOut : StDrain;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      StDrain: begin
        pe_en = 1'b1;
        if (lat_q == LatLast) begin
          state_d = StOut;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done_d = 1'b1;
          if (start) begin
            state_d   = StAccum;
            tap_d     = '0;
            start_acc = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      tap_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign tap_idx   = (state_q == StAccum) ? tap_q : '0;
  // Zero-product select is idle-high, but every output must read 0 while reset is held
  assign mult_seln = mult_sel_raw & rstn;
  assign done      = done_q;

`ifdef PE_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_evt;

  assign stall_evt = ((state_q == StAccum) && !in_valid) || ((state_q == StOut) && !out_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pe_tap_sequencer.sv
// Self-checking bench for pe_tap_sequencer (KERNEL_SIZE=9, PIPE_LAT=2): vector table plus
// hand-written stall, backpressure, back-to-back and mid-window reset sequences.
module tb_pe_tap_sequencer;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic        pe_en;
  logic        mult_seln;
  logic        acc_seln;
  logic [3:0]  tap_idx;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic [31:0] stall_cnt;

  pe_tap_sequencer #(
    .KERNEL_SIZE(9),
    .PIPE_LAT   (2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pe_en    (pe_en),
    .mult_seln(mult_seln),
    .acc_seln (acc_seln),
    .tap_idx  (tap_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       in_ready;
    logic       pe_en;
    logic       mult_seln;
    logic       acc_seln;
    logic [3:0] tap_idx;
    logic       out_valid;
    logic       done;
  } outs_t;

  typedef struct {
    logic  start;
    logic  in_valid;
    logic  out_ready;
    outs_t exp;
    outs_t mask;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl[15];
  vec_t sb_q[$];

`ifdef PE_SEQ_STALL_CNT_EN
  localparam logic [31:0] ExpStall = 32'd5;
`else
  localparam logic [31:0] ExpStall = 32'd0;
`endif

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else n_pass++;
  endfunction

  function automatic outs_t sample();
    return outs_t'({busy, in_ready, pe_en, mult_seln, acc_seln, tap_idx, out_valid, done});
  endfunction

  // Set inputs for the current cycle, then wait to the mid-cycle sampling point.
  task automatic drive(input logic s, input logic iv, input logic ordy);
    start     = s;
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t  e;
    outs_t got;
    sb_q.push_back(v);
    drive(v.start, v.in_valid, v.out_ready);
    got = sample();
    e   = sb_q.pop_front();
    check($sformatf("t1_cycle%0d", idx), 32'(got & e.mask), 32'(e.exp & e.mask));
    adv();
  endtask

  initial begin
    outs_t o;
    outs_t m;

    // T1 expectation table, cycle 0 = start cycle
    for (int c = 0; c < 15; c++) begin
      o = '0;
      m = '1;
      if (c == 0) begin
        o.mult_seln = 1'b1;
      end else if (c <= 9) begin
        o.busy     = 1'b1;
        o.in_ready = 1'b1;
        o.pe_en    = 1'b1;
        o.acc_seln = (c == 1);
        o.tap_idx  = 4'(c - 1);
      end else if (c <= 11) begin
        o.busy      = 1'b1;
        o.pe_en     = 1'b1;
        o.mult_seln = 1'b1;
        m.tap_idx   = '0;
      end else if (c == 12) begin
        o.busy      = 1'b1;
        o.out_valid = 1'b1;
        m.tap_idx   = '0;
        m.mult_seln = 1'b0;
      end else begin
        o.mult_seln = 1'b1;
        o.done      = (c == 13);
        m.tap_idx   = '0;
      end
      tbl[c] = '{start: (c == 0), in_valid: (c >= 1 && c <= 9), out_ready: 1'b1, exp: o, mask: m};
    end

    rstn      = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_outputs", 32'(sample()), 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    adv();

    // T1
    for (int i = 0; i < 15; i++) run_vec(tbl[i], i);

    // T2 + T6: two-cycle stall at tap 3, then three cycles of OUT backpressure
    drive(1'b1, 1'b0, 1'b0);
    adv();
    for (int c = 1; c <= 13; c++) begin
      drive(1'b0, (c != 4) && (c != 5), 1'b0);
      if (c == 4 || c == 5) begin
        check($sformatf("t2_stall_pe_en_c%0d", c), 32'(pe_en), 32'd0);
        check($sformatf("t2_stall_tap_c%0d", c), 32'(tap_idx), 32'd3);
      end
      if (c == 13) check("t2_no_early_out_valid", 32'(out_valid), 32'd0);
      adv();
    end
    for (int c = 14; c <= 16; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      check($sformatf("t2_out_hold_c%0d", c), 32'({out_valid, busy, pe_en, done}), 32'b1100);
      adv();
    end
    drive(1'b0, 1'b0, 1'b1);
    check("t2_out_handshake", 32'({out_valid, done}), 32'b10);
    adv();
    drive(1'b0, 1'b0, 1'b0);
    check("t2_done_pulse", 32'({done, busy}), 32'b10);
    check("t6_stall_cnt", stall_cnt, ExpStall);
    adv();

    // T3: five cycles of backpressure, then T4 back-to-back restart
    drive(1'b1, 1'b0, 1'b0);
    adv();
    for (int c = 1; c <= 11; c++) begin
      drive(1'b0, c <= 9, 1'b0);
      adv();
    end
    for (int c = 12; c <= 16; c++) begin
      drive(1'b0, 1'b0, 1'b0);
      check($sformatf("t3_backpressure_c%0d", c), 32'({out_valid, busy, pe_en, done}), 32'b1100);
      adv();
    end
    drive(1'b1, 1'b0, 1'b1);
    check("t4_handshake_restart", 32'({out_valid, busy, done}), 32'b110);
    adv();
    drive(1'b0, 1'b1, 1'b0);
    check("t4_restart_state", 32'({done, busy, in_ready, acc_seln, tap_idx}), 32'b1111_0000);
    adv();
    for (int c = 19; c <= 22; c++) begin
      drive(1'b0, 1'b1, 1'b0);
      check($sformatf("t4_tap_c%0d", c), 32'({busy, acc_seln, tap_idx}), 32'({2'b10, 4'(c - 18)}));
      if (c < 22) adv();
    end

    // T5: asynchronous reset at tap 4
    rstn = 1'b0;
    #1;
    check("t5_reset_outputs", 32'(sample()), 32'd0);
    check("t5_reset_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    adv();
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 1'b1, 1'b1);
      check($sformatf("t5_idle_c%0d", c), 32'({busy, in_ready, pe_en, mult_seln, out_valid, done}),
            32'b000100);
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
